// File: rtl/frame_fader.sv
// Frame-synchronous brightness fader placed after the game-over overlay.
// Registers the timing bus and scales RGB by the current fade level.
module frame_fader #(
    parameter int FADE_STEPS      = 16,
    parameter int FRAMES_PER_STEP = 4,
    localparam int LW = $clog2(FADE_STEPS) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fade_req,
    input  logic [9:0]    hcount_in,
    input  logic          hsync_in,
    input  logic [9:0]    vcount_in,
    input  logic          vsync_in,
    input  logic [23:0]   rgb_in,
    input  logic          blnk_in,
    output logic [9:0]    hcount_out,
    output logic          hsync_out,
    output logic [9:0]    vcount_out,
    output logic          vsync_out,
    output logic [23:0]   rgb_out,
    output logic          blnk_out,
    output logic          fade_busy,
    output logic [LW-1:0] fade_level
);

    localparam int SH = $clog2(FADE_STEPS);
    localparam int PW = 8 + LW;
    localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [LW-1:0] LMAX = LW'(FADE_STEPS);

    typedef enum logic [1:0] {
        BRIGHT,
        DARKEN,
        DARK,
        BRIGHTEN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          vsync_prev;
    logic          tick;
    logic          step;

    assign tick = vsync_in & ~vsync_prev;
    assign step = (cnt == CW'(FRAMES_PER_STEP - 1));

    function automatic logic [7:0] scale(input logic [7:0] c,
                                         input logic [LW-1:0] l);
        logic [PW-1:0] p;
        p = PW'(c) * PW'(l);
        return 8'(p >> SH);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_out <= '0;
            hsync_out  <= 1'b0;
            vcount_out <= '0;
            vsync_out  <= 1'b0;
            blnk_out   <= 1'b0;
            rgb_out    <= '0;
            fade_busy  <= 1'b0;
            fade_level <= LMAX;
            state      <= BRIGHT;
            cnt        <= '0;
            vsync_prev <= 1'b1;
        end else begin
            hcount_out <= hcount_in;
            hsync_out  <= hsync_in;
            vcount_out <= vcount_in;
            vsync_out  <= vsync_in;
            blnk_out   <= blnk_in;
            vsync_prev <= vsync_in;
            // Scaling uses the level held before this edge, even on a tick.
            if (blnk_in) begin
                rgb_out <= '0;
            end else begin
                rgb_out <= {scale(rgb_in[23:16], fade_level),
                            scale(rgb_in[15:8],  fade_level),
                            scale(rgb_in[7:0],   fade_level)};
            end
            if (tick) begin
                unique case (state)
                    BRIGHT: begin
                        if (fade_req) begin
                            state     <= DARKEN;
                            cnt       <= '0;
                            fade_busy <= 1'b1;
                        end
                    end
                    DARKEN: begin
                        if (!fade_req) begin
                            state <= BRIGHTEN;
                            cnt   <= '0;
                        end else if (step) begin
                            cnt <= '0;
                            // Saturate at black; a reversal may re-enter at 0.
                            if (fade_level <= LW'(1)) begin
                                fade_level <= '0;
                                state      <= DARK;
                                fade_busy  <= 1'b0;
                            end else begin
                                fade_level <= fade_level - LW'(1);
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    DARK: begin
                        if (!fade_req) begin
                            state     <= BRIGHTEN;
                            cnt       <= '0;
                            fade_busy <= 1'b1;
                        end
                    end
                    BRIGHTEN: begin
                        if (fade_req) begin
                            state <= DARKEN;
                            cnt   <= '0;
                        end else if (step) begin
                            cnt <= '0;
                            if (fade_level >= LMAX - LW'(1)) begin
                                fade_level <= LMAX;
                                state      <= BRIGHT;
                                fade_busy  <= 1'b0;
                            end else begin
                                fade_level <= fade_level + LW'(1);
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state     <= BRIGHT;
                        fade_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_fader.sv
// Randomized bench for frame_fader against a tick-level fade model.
module tb_frame_fader;

    localparam int FS  = 16;
    localparam int FPS = 2;
    localparam int LW  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fade_req = 1'b0;
    logic [9:0]    hcount_in = '0;
    logic          hsync_in = 1'b0;
    logic [9:0]    vcount_in = '0;
    logic          vsync_in = 1'b1;
    logic [23:0]   rgb_in = '0;
    logic          blnk_in = 1'b0;
    logic [9:0]    hcount_out;
    logic          hsync_out;
    logic [9:0]    vcount_out;
    logic          vsync_out;
    logic [23:0]   rgb_out;
    logic          blnk_out;
    logic          fade_busy;
    logic [LW-1:0] fade_level;

    frame_fader #(.FADE_STEPS(FS), .FRAMES_PER_STEP(FPS)) dut (
        .clk(clk), .rst(rst), .fade_req(fade_req),
        .hcount_in(hcount_in), .hsync_in(hsync_in),
        .vcount_in(vcount_in), .vsync_in(vsync_in),
        .rgb_in(rgb_in), .blnk_in(blnk_in),
        .hcount_out(hcount_out), .hsync_out(hsync_out),
        .vcount_out(vcount_out), .vsync_out(vsync_out),
        .rgb_out(rgb_out), .blnk_out(blnk_out),
        .fade_busy(fade_busy), .fade_level(fade_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          m_lev = FS;
    bit          m_dir = 1'b0;
    bit          m_busy = 1'b0;
    int          m_cnt = 0;
    bit          m_vprev = 1'b1;
    logic [22:0] e_bus = '0;
    logic [23:0] e_rgb = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] scale(input logic [7:0] c, input int l);
        return 8'((int'(c) * l) / FS);
    endfunction

    task automatic model_reset();
        m_lev = FS;
        m_dir = 1'b0;
        m_busy = 1'b0;
        m_cnt = 0;
        m_vprev = 1'b1;
        e_bus = '0;
        e_rgb = '0;
    endtask

    // Fade model: direction follows fade_req at ticks; each FPS ticks of
    // a running fade move the level one step toward the target.
    task automatic model_edge();
        int tgt;
        if (!rst) begin
            e_bus = '0;
            e_rgb = '0;
            return;
        end
        e_bus = {hcount_in, hsync_in, vcount_in, vsync_in, blnk_in};
        e_rgb = blnk_in ? 24'h0 : {scale(rgb_in[23:16], m_lev),
                                   scale(rgb_in[15:8], m_lev),
                                   scale(rgb_in[7:0], m_lev)};
        if (vsync_in && !m_vprev) begin
            if (fade_req != m_dir) begin
                m_dir = fade_req;
                m_cnt = 0;
                m_busy = 1'b1;
            end else if (m_busy) begin
                if (m_cnt == FPS - 1) begin
                    m_cnt = 0;
                    tgt = m_dir ? 0 : FS;
                    if (m_lev < tgt) m_lev++;
                    else if (m_lev > tgt) m_lev--;
                    if (m_lev == tgt) m_busy = 1'b0;
                end else begin
                    m_cnt++;
                end
            end
        end
        m_vprev = vsync_in;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("bus", 32'({hcount_out, hsync_out, vcount_out,
                          vsync_out, blnk_out}), 32'(e_bus));
        check("rgb", 32'(rgb_out), 32'(e_rgb));
        check("level", 32'(fade_level), 32'(m_lev));
        check("busy", 32'(fade_busy), 32'(m_busy));
        @(negedge clk);
    endtask

    task automatic rand_pix();
        hcount_in = 10'($urandom);
        vcount_in = 10'($urandom);
        hsync_in  = 1'($urandom);
        rgb_in    = 24'($urandom);
        blnk_in   = ($urandom_range(0, 3) == 0);
    endtask

    task automatic frame(input int lo, input int hi, input logic req);
        fade_req = req;
        for (int i = 0; i < lo; i++) begin
            vsync_in = 1'b0;
            rand_pix();
            cyc();
        end
        for (int i = 0; i < hi; i++) begin
            vsync_in = 1'b1;
            rand_pix();
            cyc();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen8;
        model_reset();
        rand_pix();
        @(negedge clk);
        cyc();
        cyc();
        check("rst_level", 32'(fade_level), 32'd16);
        check("rst_rgb", 32'(rgb_out), 32'd0);

        // Release with vsync held high: no tick may follow.
        rst = 1'b1;
        vsync_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_pix();
            cyc();
        end
        check("rel_level", 32'(fade_level), 32'd16);
        check("rel_busy", 32'(fade_busy), 32'd0);

        fade_req = 1'b0;
        vsync_in = 1'b0;
        rgb_in = 24'h8040FF;
        blnk_in = 1'b0;
        cyc();
        check("pass", 32'(rgb_out), 32'h8040FF);
        blnk_in = 1'b1;
        cyc();
        check("blank", 32'(rgb_out), 32'h0);

        frame(8, 2, 1'b0);
        frame(8, 2, 1'b0);

        // Short fade_req pulse between ticks must be ignored.
        for (int i = 0; i < 130; i++) begin
            vsync_in = 1'b0;
            fade_req = (i >= 10 && i < 110);
            rand_pix();
            cyc();
        end
        frame(0, 2, 1'b0);
        check("glitch_level", 32'(fade_level), 32'd16);
        check("glitch_busy", 32'(fade_busy), 32'd0);

        frame(8, 2, 1'b1);
        check("entry_busy", 32'(fade_busy), 32'd1);
        check("entry_level", 32'(fade_level), 32'd16);
        frame(8, 2, 1'b1);
        frame(8, 2, 1'b1);
        check("first_step", 32'(fade_level), 32'd15);
        seen8 = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (m_lev == 8 && !seen8) begin
                seen8 = 1'b1;
                vsync_in = 1'b0;
                rgb_in = 24'h8040FF;
                blnk_in = 1'b0;
                cyc();
                check("half", 32'(rgb_out), 32'h40207F);
            end
            frame(8, 2, 1'b1);
        end
        check("dark_level", 32'(fade_level), 32'd0);
        check("dark_busy", 32'(fade_busy), 32'd0);

        for (int k = 0; k < 100 && (m_busy || m_lev != FS); k++)
            frame(8, 2, 1'b0);
        check("bright_level", 32'(fade_level), 32'd16);

        for (int k = 0; k < 100 && m_lev != 10; k++)
            frame(8, 2, 1'b1);
        check("rev_at10", 32'(fade_level), 32'd10);
        frame(8, 2, 1'b0);
        check("rev_busy", 32'(fade_busy), 32'd1);
        check("rev_level", 32'(fade_level), 32'd10);
        for (int k = 0; k < 100 && m_busy; k++)
            frame(8, 2, 1'b0);
        check("rev_end_level", 32'(fade_level), 32'd16);
        check("rev_end_busy", 32'(fade_busy), 32'd0);

        for (int k = 0; k < 40; k++)
            frame($urandom_range(2, 9), $urandom_range(1, 3),
                  1'($urandom_range(0, 3) != 0));

        // Asynchronous reset in the middle of a line while fading.
        for (int k = 0; k < 100 && m_lev == 0; k++)
            frame(8, 2, 1'b0);
        frame(8, 2, 1'b1);
        frame(8, 2, 1'b1);
        frame(8, 2, 1'b1);
        vsync_in = 1'b0;
        fade_req = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("arst_rgb", 32'(rgb_out), 32'h0);
        check("arst_bus", 32'({hcount_out, hsync_out, vcount_out,
                               vsync_out, blnk_out}), 32'h0);
        check("arst_level", 32'(fade_level), 32'd16);
        check("arst_busy", 32'(fade_busy), 32'd0);
        model_reset();
        cyc();
        cyc();
        rst = 1'b1;
        vsync_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_pix();
            cyc();
        end
        for (int k = 0; k < 10; k++)
            frame(8, 2, 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
